// File: rtl/pid_pwm_out_pkg.sv
// Shared defaults and duty-mapping helper for the PID PWM output stage.
package pid_pwm_out_pkg;

    localparam int DEF_OUTPUT_WIDTH  = 16;
    localparam int DEF_PWM_CNT_WIDTH = 10;
    localparam int DEF_DEAD_TIME     = 2;
    localparam int DEF_TRIG_DIV      = 1;

    // Offset that moves a signed control value onto an unsigned 0..2^width-1 scale.
    function automatic logic [63:0] duty_offset(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary gate driver: delays each output's rising edge by DEAD_TIME clocks,
// drops it one clock after its source falls, and idles low while force_off is set.
module pwm_deadtime #(
    parameter int DEAD_TIME = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic force_off,
    input  logic raw,
    output logic pwm_h,
    output logic pwm_l
);

    localparam int CW = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;
    localparam logic [CW-1:0] DT = CW'(DEAD_TIME);

    logic [1:0]    want;
    logic [1:0]    out_q;
    logic [CW-1:0] delay_cnt [2];

    assign want = {~raw, raw};

    // Channel 0 is the high side, channel 1 the low side; a source drop cancels any pending delay.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset || force_off || !want[i]) begin
                out_q[i]     <= 1'b0;
                delay_cnt[i] <= '0;
            end else if (!out_q[i]) begin
                if (delay_cnt[i] == DT) begin
                    out_q[i] <= 1'b1;
                end else begin
                    delay_cnt[i] <= delay_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pwm_h = out_q[0];
    assign pwm_l = out_q[1];

endmodule

// File: rtl/pid_pwm_out.sv
// PID output stage: maps the signed control value to a double-buffered PWM duty,
// drives dead-timed complementary gates and issues carrier-locked PID triggers.
module pid_pwm_out
    import pid_pwm_out_pkg::*;
#(
    parameter int OUTPUT_WIDTH  = DEF_OUTPUT_WIDTH,
    parameter int PWM_CNT_WIDTH = DEF_PWM_CNT_WIDTH,
    parameter int DEAD_TIME     = DEF_DEAD_TIME,
    parameter int TRIG_DIV      = DEF_TRIG_DIV
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic [PWM_CNT_WIDTH-1:0]       period,
    input  logic signed [OUTPUT_WIDTH-1:0] sig_in,
    input  logic                           sig_valid,
    output logic                           trig,
    output logic                           pwm_h,
    output logic                           pwm_l,
    output logic [PWM_CNT_WIDTH-1:0]       duty,
    output logic                           overrun
);

    localparam int W   = PWM_CNT_WIDTH;
    localparam int PW  = OUTPUT_WIDTH + PWM_CNT_WIDTH;
    localparam int TDW = (TRIG_DIV > 1) ? $clog2(TRIG_DIV) : 1;
    localparam logic [TDW-1:0] TDIV_LAST = TDW'(TRIG_DIV - 1);
    localparam logic [OUTPUT_WIDTH-1:0] DUTY_OFFSET = OUTPUT_WIDTH'(duty_offset(OUTPUT_WIDTH));

    logic [W-1:0]            cnt;
    logic [W-1:0]            period_sh;
    logic [W-1:0]            eff_period;
    logic [W-1:0]            pending;
    logic [W-1:0]            pending_next;
    logic                    pending_valid;
    logic [OUTPUT_WIDTH-1:0] u_reg;
    logic                    u_valid;
    logic [TDW-1:0]          trig_div_cnt;
    logic                    running;
    logic                    wrap;
    logic                    raw;
    logic [PW-1:0]           product;

    assign eff_period   = (period_sh < W'(2)) ? W'(2) : period_sh;
    assign wrap         = en && running && (cnt == eff_period - 1'b1);
    assign product      = PW'(u_reg) * PW'(eff_period);
    assign pending_next = W'(product >> OUTPUT_WIDTH);

    // The counter starts one clock after en rises, so that first clock is treated as idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            period_sh     <= '1;
            duty          <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            u_reg         <= '0;
            u_valid       <= 1'b0;
            trig_div_cnt  <= '0;
            running       <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            running <= en;
            u_valid <= sig_valid;
            if (sig_valid) begin
                u_reg <= sig_in ^ DUTY_OFFSET;
            end

            // A wrap on the same clock as a pending write consumes the old value, so that is not an overrun.
            overrun <= u_valid && pending_valid && !wrap;
            if (u_valid) begin
                pending       <= pending_next;
                pending_valid <= 1'b1;
            end else if (wrap) begin
                pending_valid <= 1'b0;
            end

            if (wrap) begin
                period_sh <= period;
                if (pending_valid) begin
                    duty <= pending;
                end
            end

            if (!en) begin
                cnt          <= '0;
                trig_div_cnt <= '0;
            end else if (running) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
                if (cnt == '0) begin
                    trig_div_cnt <= (trig_div_cnt == TDIV_LAST) ? '0 : trig_div_cnt + 1'b1;
                end
            end
        end
    end

    assign trig = running && (cnt == '0) && (trig_div_cnt == '0);
    assign raw  = cnt < duty;

    pwm_deadtime #(
        .DEAD_TIME(DEAD_TIME)
    ) u_deadtime (
        .clk      (clk),
        .reset    (reset),
        .force_off(~(en & running)),
        .raw      (raw),
        .pwm_h    (pwm_h),
        .pwm_l    (pwm_l)
    );

endmodule

// File: tb/tb_pid_pwm_out.sv
// Self-checking bench for pid_pwm_out: directed scenarios plus random strobes,
// period changes and enable drops, checked every clock against a behavioural model.
module tb_pid_pwm_out;

    localparam int OW = 16;
    localparam int CW = 10;
    localparam int DT = 2;
    localparam int TD = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 en;
    logic [CW-1:0]        period;
    logic signed [OW-1:0] sig_in;
    logic                 sig_valid;
    logic                 trig;
    logic                 pwm_h;
    logic                 pwm_l;
    logic [CW-1:0]        duty;
    logic                 overrun;

    int checks = 0;
    int errors = 0;

    pid_pwm_out #(
        .OUTPUT_WIDTH (OW),
        .PWM_CNT_WIDTH(CW),
        .DEAD_TIME    (DT),
        .TRIG_DIV     (TD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .period   (period),
        .sig_in   (sig_in),
        .sig_valid(sig_valid),
        .trig     (trig),
        .pwm_h    (pwm_h),
        .pwm_l    (pwm_l),
        .duty     (duty),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int u;
    } map_t;

    int   m_cnt, m_psh, m_duty, m_pend, m_tdc, edge_no;
    bit   m_pv, m_run, m_ovr;
    map_t pipe[$];
    bit   hist_h[$];
    bit   hist_l[$];

    function automatic bit allSet(input bit q[$]);
        bit r = 1'b1;
        foreach (q[i]) r &= q[i];
        return r;
    endfunction

    // Model of one clock edge; the gate histories record whether each side was wanted and enabled.
    task automatic modelEdge();
        int    p;
        bit    wrap, raw, forced, write_now;
        map_t  e;
        edge_no++;
        raw    = (m_cnt < m_duty);
        forced = reset || !(en && m_run);
        hist_h.push_front(!forced && raw);
        hist_l.push_front(!forced && !raw);
        if (hist_h.size() > DT + 1) void'(hist_h.pop_back());
        if (hist_l.size() > DT + 1) void'(hist_l.pop_back());
        if (reset) begin
            m_cnt = 0; m_psh = (1 << CW) - 1; m_duty = 0; m_pend = 0;
            m_pv = 0; m_tdc = 0; m_run = 0; m_ovr = 0;
            pipe.delete();
            return;
        end
        p         = (m_psh < 2) ? 2 : m_psh;
        wrap      = en && m_run && (m_cnt == p - 1);
        write_now = (pipe.size() > 0) && (pipe[0].due == edge_no);
        m_ovr     = write_now && m_pv && !wrap;
        if (wrap && m_pv) begin
            m_duty = m_pend;
            m_pv   = 0;
        end
        if (write_now) begin
            e      = pipe.pop_front();
            m_pend = int'((longint'(e.u) * p) / 65536);
            m_pv   = 1;
        end
        if (sig_valid) pipe.push_back('{edge_no + 1, int'(sig_in) + 32768});
        if (wrap) m_psh = int'(period);
        if (!en) begin
            m_cnt = 0;
            m_tdc = 0;
        end else if (m_run) begin
            if (m_cnt == 0) m_tdc = (m_tdc + 1) % TD;
            m_cnt = wrap ? 0 : m_cnt + 1;
        end
        m_run = en;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    task automatic checkAll();
        checkOutput("trig", 32'(trig), 32'(m_run && m_cnt == 0 && m_tdc == 0));
        checkOutput("pwm_h", 32'(pwm_h), 32'(allSet(hist_h)));
        checkOutput("pwm_l", 32'(pwm_l), 32'(allSet(hist_l)));
        checkOutput("duty", 32'(duty), 32'(m_duty));
        checkOutput("overrun", 32'(overrun), 32'(m_ovr));
        checkOutput("no_overlap", 32'(pwm_h & pwm_l), 32'd0);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic applyStimulus(input int value);
        sig_valid = 1'b1;
        sig_in    = OW'(value);
        stepCycle();
        sig_valid = 1'b0;
    endtask

    task automatic waitCnt(input int target);
        int n = 0;
        while (!(m_cnt == target && m_run && en) && n < 3000) begin
            stepCycle();
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $error("FAIL wait_cnt_%0d: observed timeout expected count reached", target);
        end
    endtask

    initial begin
        int n, ovr_seen;
        for (int i = 0; i <= DT; i++) begin
            hist_h.push_back(1'b0);
            hist_l.push_back(1'b0);
        end
        reset = 1'b1; en = 1'b0; period = CW'(100); sig_in = '0; sig_valid = 1'b0;
        runCycles(3);
        checkOutput("reset_trig", 32'(trig), 32'd0);
        checkOutput("reset_pwm_h", 32'(pwm_h), 32'd0);
        checkOutput("reset_pwm_l", 32'(pwm_l), 32'd0);
        checkOutput("reset_duty", 32'(duty), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);

        reset = 1'b0; en = 1'b1;
        $display("[TB] running first full-scale period");
        runCycles(1100);

        $display("[TB] mid-scale, zero and full-scale duty");
        applyStimulus(0);
        runCycles(300);
        checkOutput("duty_mid", 32'(duty), 32'd50);
        applyStimulus(-32768);
        runCycles(300);
        checkOutput("duty_zero", 32'(duty), 32'd0);
        checkOutput("zero_pwm_h", 32'(pwm_h), 32'd0);
        checkOutput("zero_pwm_l", 32'(pwm_l), 32'd1);
        applyStimulus(32767);
        runCycles(300);
        checkOutput("duty_full", 32'(duty), 32'd99);

        $display("[TB] overrun with two strobes in one period");
        waitCnt(10);
        applyStimulus(0);
        waitCnt(20);
        applyStimulus(16384);
        ovr_seen = 0;
        n = 0;
        while (m_cnt != 0 && n < 200) begin
            stepCycle();
            ovr_seen += int'(overrun);
            n++;
        end
        checkOutput("overrun_count", 32'(ovr_seen), 32'd1);
        checkOutput("duty_after_overrun", 32'(duty), 32'd75);

        $display("[TB] trigger spacing and shadowed duty update");
        applyStimulus(0);
        runCycles(250);
        n = 0;
        while (trig !== 1'b1 && n < 500) begin stepCycle(); n++; end
        n = 0;
        do begin stepCycle(); n++; end while (trig !== 1'b1 && n < 500);
        checkOutput("trig_interval", 32'(n), 32'd200);
        waitCnt(40);
        applyStimulus(16384);
        runCycles(5);
        checkOutput("duty_hold", 32'(duty), 32'd50);
        waitCnt(0);
        checkOutput("duty_at_wrap", 32'(duty), 32'd75);

        $display("[TB] enable drop and re-enable");
        waitCnt(30);
        en = 1'b0;
        stepCycle();
        checkOutput("idle_pwm_h", 32'(pwm_h), 32'd0);
        checkOutput("idle_pwm_l", 32'(pwm_l), 32'd0);
        checkOutput("idle_trig", 32'(trig), 32'd0);
        runCycles(5);
        en = 1'b1;
        n = 0;
        do begin stepCycle(); n++; end while (trig !== 1'b1 && n < 50);
        checkOutput("reenable_trig_delay", 32'(n), 32'd1);
        runCycles(20);

        $display("[TB] random strobes, periods and enable drops");
        for (int i = 0; i < 3000; i++) begin
            sig_valid = ($urandom_range(0, 39) == 0);
            sig_in    = OW'($urandom);
            if ($urandom_range(0, 149) == 0) period = CW'($urandom_range(0, 150));
            if (en && $urandom_range(0, 599) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
            stepCycle();
        end
        sig_valid = 1'b0;

        $display("[TB] reset in the middle of a period");
        en = 1'b1; period = CW'(100);
        runCycles(400);
        waitCnt(50);
        reset = 1'b1;
        stepCycle();
        checkOutput("midreset_trig", 32'(trig), 32'd0);
        checkOutput("midreset_pwm_h", 32'(pwm_h), 32'd0);
        checkOutput("midreset_pwm_l", 32'(pwm_l), 32'd0);
        checkOutput("midreset_duty", 32'(duty), 32'd0);
        checkOutput("midreset_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        runCycles(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
